// File: rtl/ram2_arbiter.sv
// ram2_arbiter
//
// Shares the single RAM2 SRAM port between the instruction-fetch (IF) stage
// and the execute/memory (EXE) stage. Each requester holds a level request
// and receives a one-cycle done pulse. One transaction at a time is
// forwarded to the RAM2 controller over a req/ack handshake.
//
// Optional feature macro: RAM2_ARB_FAIR_EN
//   defined   - IF is forced through after MAX_EXE_BURST consecutive EXE
//               grants that happened while IF was waiting.
//   undefined - strict EXE priority; IF may starve under continuous EXE load.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   if_req, if_addr                IF read request (level) and address
//   if_rdata, if_done, stall_if    IF read data, done pulse, stall
//   exe_req, exe_we, exe_addr,     EXE request (level), write enable,
//   exe_wdata                      address and write data
//   exe_rdata, exe_done, stall_exe EXE read data, done pulse, stall
//   mem_req, mem_we, mem_addr,     request to the RAM2 controller, held
//   mem_wdata                      until mem_ack
//   mem_ack, mem_rdata             controller completion and read data
//   owner                          current grant: 00 idle, 01 IF, 10 EXE

module ram2_arbiter #(
    parameter int ADDR_W        = 18,
    parameter int DATA_W        = 16,
    parameter int MAX_EXE_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              stall_if,
    input  logic              exe_req,
    input  logic              exe_we,
    input  logic [ADDR_W-1:0] exe_addr,
    input  logic [DATA_W-1:0] exe_wdata,
    output logic [DATA_W-1:0] exe_rdata,
    output logic              exe_done,
    output logic              stall_exe,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    if (MAX_EXE_BURST < 1 || MAX_EXE_BURST > 15) begin : g_bad_burst
        $error("MAX_EXE_BURST must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        BUSY_IF  = 2'b01,
        BUSY_EXE = 2'b10
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   grant_if;
    logic   grant_exe;
    logic   if_priority;
    logic   done_cycle;

    // In the done cycle the request levels still belong to the transaction
    // that just finished; a request only counts as new from the next cycle.
    assign done_cycle = if_done | exe_done;

`ifdef RAM2_ARB_FAIR_EN
    logic [3:0] burst_cnt;

    assign if_priority = (burst_cnt >= 4'(MAX_EXE_BURST));

    // Counts EXE grants that overtook a waiting IF; saturates at 15.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= 4'd0;
        end else if (grant_if) begin
            burst_cnt <= 4'd0;
        end else if (grant_exe) begin
            if (!if_req)
                burst_cnt <= 4'd0;
            else if (burst_cnt != 4'hF)
                burst_cnt <= burst_cnt + 4'd1;
        end
    end
`else
    assign if_priority = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and grant decision
    always_comb begin
        grant_if  = 1'b0;
        grant_exe = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!done_cycle) begin
                    if (exe_req && !(if_req && if_priority)) begin
                        grant_exe = 1'b1;
                        state_nxt = BUSY_EXE;
                    end else if (if_req) begin
                        grant_if  = 1'b1;
                        state_nxt = BUSY_IF;
                    end
                end
            end
            BUSY_IF, BUSY_EXE: begin
                if (mem_ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered memory command, done pulses and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            exe_done  <= 1'b0;
            if_rdata  <= '0;
            exe_rdata <= '0;
        end else begin
            if_done  <= (state == BUSY_IF)  && mem_ack;
            exe_done <= (state == BUSY_EXE) && mem_ack;
            if (grant_exe) begin
                mem_we    <= exe_we;
                mem_addr  <= exe_addr;
                mem_wdata <= exe_wdata;
            end else if (grant_if) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
            end
            if (state == BUSY_IF && mem_ack)
                if_rdata <= mem_rdata;
            if (state == BUSY_EXE && mem_ack && !mem_we)
                exe_rdata <= mem_rdata;
        end
    end

    // Outputs derived from state
    always_comb begin
        mem_req   = (state != IDLE);
        stall_if  = if_req & ~if_done;
        stall_exe = exe_req & ~exe_done;
        case (state)
            BUSY_IF:  owner = 2'b01;
            BUSY_EXE: owner = 2'b10;
            default:  owner = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_ram2_arbiter.sv
module tb_ram2_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;
`ifdef RAM2_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          stall_if;
    logic          exe_req = 1'b0;
    logic          exe_we = 1'b0;
    logic [AW-1:0] exe_addr = '0;
    logic [DW-1:0] exe_wdata = '0;
    logic [DW-1:0] exe_rdata;
    logic          exe_done;
    logic          stall_exe;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [1:0]    owner;

    int n_checks = 0;
    int n_fail   = 0;

    ram2_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_EXE_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .stall_if(stall_if),
        .exe_req(exe_req), .exe_we(exe_we), .exe_addr(exe_addr),
        .exe_wdata(exe_wdata), .exe_rdata(exe_rdata), .exe_done(exe_done),
        .stall_exe(stall_exe),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .owner(owner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string         name;
        logic          ir;
        logic [AW-1:0] ia;
        logic          er;
        logic          ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        logic          ack;
        logic [DW-1:0] rd;
        logic          x_req;
        logic          x_we;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wdata;
        logic [1:0]    x_owner;
        logic          x_idone;
        logic          x_edone;
        logic [DW-1:0] x_irdata;
        logic [DW-1:0] x_erdata;
        logic          x_sif;
        logic          x_sexe;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string n, logic ir, logic [AW-1:0] ia, logic er,
                                logic ew, logic [AW-1:0] ea, logic [DW-1:0] ewd,
                                logic ack, logic [DW-1:0] rd, logic xr, logic xw,
                                logic [AW-1:0] xa, logic [DW-1:0] xwd, logic [1:0] xo,
                                logic xid, logic xed, logic [DW-1:0] xir,
                                logic [DW-1:0] xer, logic xsi, logic xse);
        vec_t v;
        v.name = n; v.ir = ir; v.ia = ia; v.er = er; v.ew = ew; v.ea = ea;
        v.ewd = ewd; v.ack = ack; v.rd = rd; v.x_req = xr; v.x_we = xw;
        v.x_addr = xa; v.x_wdata = xwd; v.x_owner = xo; v.x_idone = xid;
        v.x_edone = xed; v.x_irdata = xir; v.x_erdata = xer; v.x_sif = xsi;
        v.x_sexe = xse;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = '0; exe_req = 1'b0; exe_we = 1'b0;
        exe_addr = '0; exe_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        if_req = v.ir; if_addr = v.ia; exe_req = v.er; exe_we = v.ew;
        exe_addr = v.ea; exe_wdata = v.ewd; mem_ack = v.ack; mem_rdata = v.rd;
        #1;
        chk({v.name, ".mem_req"}, 32'(mem_req), 32'(v.x_req));
        chk({v.name, ".owner"}, 32'(owner), 32'(v.x_owner));
        chk({v.name, ".if_done"}, 32'(if_done), 32'(v.x_idone));
        chk({v.name, ".exe_done"}, 32'(exe_done), 32'(v.x_edone));
        chk({v.name, ".if_rdata"}, 32'(if_rdata), 32'(v.x_irdata));
        chk({v.name, ".exe_rdata"}, 32'(exe_rdata), 32'(v.x_erdata));
        chk({v.name, ".stall_if"}, 32'(stall_if), 32'(v.x_sif));
        chk({v.name, ".stall_exe"}, 32'(stall_exe), 32'(v.x_sexe));
        if (v.x_req) begin
            chk({v.name, ".mem_addr"}, 32'(mem_addr), 32'(v.x_addr));
            chk({v.name, ".mem_we"}, 32'(mem_we), 32'(v.x_we));
            if (v.x_we)
                chk({v.name, ".mem_wdata"}, 32'(mem_wdata), 32'(v.x_wdata));
        end
    endtask

    initial begin
        int   if_grants;
        int   n_tr;
        logic found;
        logic [1:0] exp_own;
        logic [1:0] got_own;

        //            name  ir ia       er ew ea        ewd       ack rd        | req we addr    wdata    own id ed irdata   erdata   sif sexe
        // Single IF read, ack latency 2
        tbl.push_back(mk("A0", 1, 18'h10, 0, 0, 18'h0,    16'h0,    0, 16'h0,    0, 0, 18'h0,   16'h0,   2'd0, 0, 0, 16'h0,    16'h0,    1, 0));
        tbl.push_back(mk("A1", 1, 18'h10, 0, 0, 18'h0,    16'h0,    0, 16'h0,    1, 0, 18'h10,  16'h0,   2'd1, 0, 0, 16'h0,    16'h0,    1, 0));
        tbl.push_back(mk("A2", 1, 18'h10, 0, 0, 18'h0,    16'h0,    0, 16'h0,    1, 0, 18'h10,  16'h0,   2'd1, 0, 0, 16'h0,    16'h0,    1, 0));
        tbl.push_back(mk("A3", 1, 18'h10, 0, 0, 18'h0,    16'h0,    1, 16'hBEEF, 1, 0, 18'h10,  16'h0,   2'd1, 0, 0, 16'h0,    16'h0,    1, 0));
        tbl.push_back(mk("A4", 1, 18'h10, 0, 0, 18'h0,    16'h0,    0, 16'h0,    0, 0, 18'h0,   16'h0,   2'd0, 1, 0, 16'hBEEF, 16'h0,    0, 0));
        tbl.push_back(mk("A5", 0, 18'h10, 0, 0, 18'h0,    16'h0,    0, 16'h0,    0, 0, 18'h0,   16'h0,   2'd0, 0, 0, 16'hBEEF, 16'h0,    0, 0));
        // Simultaneous requests: EXE write first, IF after the done cycle
        tbl.push_back(mk("B0", 1, 18'h44, 1, 1, 18'h200,  16'h1234, 0, 16'h0,    0, 0, 18'h0,   16'h0,   2'd0, 0, 0, 16'hBEEF, 16'h0,    1, 1));
        tbl.push_back(mk("B1", 1, 18'h44, 1, 1, 18'h200,  16'h1234, 1, 16'hDEAD, 1, 1, 18'h200, 16'h1234, 2'd2, 0, 0, 16'hBEEF, 16'h0,    1, 1));
        tbl.push_back(mk("B2", 1, 18'h44, 1, 1, 18'h200,  16'h1234, 0, 16'h0,    0, 0, 18'h0,   16'h0,   2'd0, 0, 1, 16'hBEEF, 16'h0,    1, 0));
        tbl.push_back(mk("B3", 1, 18'h44, 0, 0, 18'h0,    16'h0,    0, 16'h0,    0, 0, 18'h0,   16'h0,   2'd0, 0, 0, 16'hBEEF, 16'h0,    1, 0));
        tbl.push_back(mk("B4", 1, 18'h44, 0, 0, 18'h0,    16'h0,    1, 16'h5A5A, 1, 0, 18'h44,  16'h0,   2'd1, 0, 0, 16'hBEEF, 16'h0,    1, 0));
        tbl.push_back(mk("B5", 1, 18'h44, 0, 0, 18'h0,    16'h0,    0, 16'h0,    0, 0, 18'h0,   16'h0,   2'd0, 1, 0, 16'h5A5A, 16'h0,    0, 0));
        tbl.push_back(mk("B6", 0, 18'h44, 0, 0, 18'h0,    16'h0,    0, 16'h0,    0, 0, 18'h0,   16'h0,   2'd0, 0, 0, 16'h5A5A, 16'h0,    0, 0));
        // Back-to-back EXE reads with zero ack latency
        tbl.push_back(mk("C0", 0, 18'h0,  1, 0, 18'h1000, 16'h0,    0, 16'h0,    0, 0, 18'h0,   16'h0,   2'd0, 0, 0, 16'h5A5A, 16'h0,    0, 1));
        tbl.push_back(mk("C1", 0, 18'h0,  1, 0, 18'h1000, 16'h0,    1, 16'h1111, 1, 0, 18'h1000, 16'h0,  2'd2, 0, 0, 16'h5A5A, 16'h0,    0, 1));
        tbl.push_back(mk("C2", 0, 18'h0,  1, 0, 18'h1000, 16'h0,    0, 16'h0,    0, 0, 18'h0,   16'h0,   2'd0, 0, 1, 16'h5A5A, 16'h1111, 0, 0));
        tbl.push_back(mk("C3", 0, 18'h0,  1, 0, 18'h1000, 16'h0,    0, 16'h0,    0, 0, 18'h0,   16'h0,   2'd0, 0, 0, 16'h5A5A, 16'h1111, 0, 1));
        tbl.push_back(mk("C4", 0, 18'h0,  1, 0, 18'h1000, 16'h0,    1, 16'h2222, 1, 0, 18'h1000, 16'h0,  2'd2, 0, 0, 16'h5A5A, 16'h1111, 0, 1));
        tbl.push_back(mk("C5", 0, 18'h0,  1, 0, 18'h1000, 16'h0,    0, 16'h0,    0, 0, 18'h0,   16'h0,   2'd0, 0, 1, 16'h5A5A, 16'h2222, 0, 0));
        tbl.push_back(mk("C6", 0, 18'h0,  1, 0, 18'h1000, 16'h0,    0, 16'h0,    0, 0, 18'h0,   16'h0,   2'd0, 0, 0, 16'h5A5A, 16'h2222, 0, 1));
        tbl.push_back(mk("C7", 0, 18'h0,  1, 0, 18'h1000, 16'h0,    1, 16'h3333, 1, 0, 18'h1000, 16'h0,  2'd2, 0, 0, 16'h5A5A, 16'h2222, 0, 1));
        tbl.push_back(mk("C8", 0, 18'h0,  1, 0, 18'h1000, 16'h0,    0, 16'h0,    0, 0, 18'h0,   16'h0,   2'd0, 0, 1, 16'h5A5A, 16'h3333, 0, 0));
        tbl.push_back(mk("C9", 0, 18'h0,  0, 0, 18'h1000, 16'h0,    0, 16'h0,    0, 0, 18'h0,   16'h0,   2'd0, 0, 0, 16'h5A5A, 16'h3333, 0, 0));

        // Reset state
        do_reset();
        #1;
        chk("rst.mem_req", 32'(mem_req), 32'd0);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.mem_addr", 32'(mem_addr), 32'd0);
        chk("rst.mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst.owner", 32'(owner), 32'd0);
        chk("rst.if_done", 32'(if_done), 32'd0);
        chk("rst.exe_done", 32'(exe_done), 32'd0);
        chk("rst.if_rdata", 32'(if_rdata), 32'd0);
        chk("rst.exe_rdata", 32'(exe_rdata), 32'd0);

        foreach (tbl[i]) apply(tbl[i]);

        // Starvation guard / strict priority with both requests held
        do_reset();
        if_req = 1'b1; if_addr = 18'h123;
        exe_req = 1'b1; exe_we = 1'b0; exe_addr = 18'h321;
        if_grants = 0;
        n_tr = FAIR ? 10 : 20;
        for (int t = 0; t < n_tr; t++) begin
            found = 1'b0;
            for (int w = 0; w < 6 && !found; w++) begin
                @(negedge clk);
                mem_ack = 1'b0;
                #1;
                if (mem_req) found = 1'b1;
            end
            chk($sformatf("starve[%0d].grant_seen", t), 32'(found), 32'd1);
            if (!found) break;
            exp_own = (FAIR && (t % 5 == 4)) ? 2'd1 : 2'd2;
            got_own = owner;
            chk($sformatf("starve[%0d].owner", t), 32'(got_own), 32'(exp_own));
            if (got_own == 2'd1) if_grants++;
            mem_ack = 1'b1;
            mem_rdata = 16'(t + 16'h40);
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            chk($sformatf("starve[%0d].if_done", t), 32'(if_done), 32'(exp_own == 2'd1));
            chk($sformatf("starve[%0d].exe_done", t), 32'(exe_done), 32'(exp_own == 2'd2));
        end
        chk("starve.if_grants", 32'(if_grants), FAIR ? 32'd2 : 32'd0);

        // Reset during BUSY_EXE with a late ack
        do_reset();
        exe_req = 1'b1; exe_we = 1'b1; exe_addr = 18'h3FFFF; exe_wdata = 16'hABCD;
        #1;
        chk("mid.idle_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        #1;
        chk("mid.busy_req", 32'(mem_req), 32'd1);
        chk("mid.busy_owner", 32'(owner), 32'd2);
        chk("mid.busy_addr", 32'(mem_addr), 32'h3FFFF);
        chk("mid.busy_wdata", 32'(mem_wdata), 32'hABCD);
        @(negedge clk);
        rst = 1'b1;
        exe_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 16'h9999;
        #1;
        chk("mid.rst_req", 32'(mem_req), 32'd0);
        chk("mid.rst_owner", 32'(owner), 32'd0);
        chk("mid.rst_we", 32'(mem_we), 32'd0);
        chk("mid.rst_addr", 32'(mem_addr), 32'd0);
        chk("mid.rst_wdata", 32'(mem_wdata), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = '0;
        #1;
        chk("mid.late_exe_done", 32'(exe_done), 32'd0);
        chk("mid.late_if_done", 32'(if_done), 32'd0);
        chk("mid.late_exe_rdata", 32'(exe_rdata), 32'd0);
        chk("mid.late_req", 32'(mem_req), 32'd0);
        exe_req = 1'b1; exe_we = 1'b0; exe_addr = 18'h55;
        @(negedge clk);
        #1;
        chk("mid.next_req", 32'(mem_req), 32'd1);
        chk("mid.next_owner", 32'(owner), 32'd2);
        chk("mid.next_addr", 32'(mem_addr), 32'h55);
        chk("mid.next_we", 32'(mem_we), 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 16'h7777;
        @(negedge clk);
        mem_ack = 1'b0;
        exe_req = 1'b0;
        #1;
        chk("mid.next_done", 32'(exe_done), 32'd1);
        chk("mid.next_rdata", 32'(exe_rdata), 32'h7777);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
